// File: rtl/demux_rr_sched.sv
// Single-word demultiplexer: captures one word, picks a lane (round-robin or fixed),
// holds it on that lane until the lane accepts it, and counts deliveries per lane.
module demux_rr_sched #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mode,
    input  logic [1:0]      sel,
    input  logic [3:0]      lane_en,
    output logic [DW-1:0]   out_data,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*CW-1:0] lane_cnt,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

    state_t         state, state_nxt;
    logic [1:0]     ptr;
    logic [1:0]     lane;
    logic [DW-1:0]  hold;
    logic           cap_mode;
    logic [1:0]     cap_sel;
    logic [CW-1:0]  cnt [4];

    logic [1:0]     rr_lane;
    logic           rr_found;
    logic [1:0]     arb_lane;
    logic           arb_ok;
    logic           accept;
    logic           handshake;

    // Descending scan so the lane closest to ptr wins.
    always_comb begin
        rr_found = 1'b0;
        rr_lane  = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (lane_en[ptr + 2'(k)]) begin
                rr_found = 1'b1;
                rr_lane  = ptr + 2'(k);
            end
        end
    end

    assign arb_lane  = cap_mode ? cap_sel : rr_lane;
    assign arb_ok    = cap_mode | rr_found;
    assign accept    = (state == IDLE) && in_valid;
    assign handshake = (state == SEND) && out_ready[lane];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ARB;
            ARB:     if (arb_ok)    state_nxt = SEND;
            SEND:    if (handshake) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold     <= '0;
            cap_mode <= 1'b0;
            cap_sel  <= 2'd0;
            lane     <= 2'd0;
            ptr      <= 2'd0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            if (accept) begin
                hold     <= in_data;
                cap_mode <= mode;
                cap_sel  <= sel;
            end
            if ((state == ARB) && arb_ok) begin
                lane <= arb_lane;
            end
            if (handshake) begin
                cnt[lane] <= cnt[lane] + 1'b1;
                if (!cap_mode) ptr <= lane + 2'd1;
            end
        end
    end

    // Gated by rst_n so no word is advertised as acceptable while reset is held.
    assign in_ready  = (state == IDLE) && rst_n;
    assign busy      = (state != IDLE);
    assign out_valid = (state == SEND) ? (4'b0001 << lane) : 4'b0000;
    assign out_data  = hold;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign lane_cnt[g*CW +: CW] = cnt[g];
    end

endmodule
